// File: rtl/scan_bist_ctrl.sv
// scan_bist_ctrl: on-chip scan tester with LFSR pattern source
// and serial MISR response compactor.
module scan_bist_ctrl #(
  parameter int          CHAIN_LEN    = 64,
  parameter int          NUM_PATTERNS = 16,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] expected_sig,
  input  logic        scan_so,
  output logic        scan_si,
  output logic        scan_en,
  output logic        test_mode,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] signature
);

  localparam int BW = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
  localparam int PW = $clog2(NUM_PATTERNS + 1);

  localparam logic [BW-1:0] BIT_LAST = BW'(CHAIN_LEN - 1);
  localparam logic [PW-1:0] PAT_NUM  = PW'(NUM_PATTERNS);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SETUP   = 3'd1;
  localparam logic [2:0] S_SHIFT   = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_UNLOAD  = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  logic [2:0]    r_state;
  logic [15:0]   r_lfsr;
  logic [15:0]   r_misr;
  logic [BW-1:0] r_bit;
  logic [PW-1:0] r_pat;
  logic          r_si;
  logic          r_en;
  logic          r_tm;
  logic          r_busy;
  logic          r_done;
  logic          r_pass;
  logic [15:0]   r_sig;

  logic [15:0]   w_lfsr_nxt;
  logic [15:0]   w_misr_nxt;
  logic [15:0]   w_misr_upd;
  logic          w_compact;
  logic          w_bit_last;
  logic [PW-1:0] w_pat_inc;

  assign w_lfsr_nxt = {r_lfsr[14:0],
    r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};

  assign w_misr_nxt = {r_misr[14:0],
    r_misr[15] ^ r_misr[13] ^ r_misr[12] ^ r_misr[10] ^ scan_so};

  // First load returns the chain's unknown reset contents: skip it.
  assign w_compact = ((r_state == S_SHIFT) && (r_pat != '0))
                   || (r_state == S_UNLOAD);

  assign w_misr_upd = w_compact ? w_misr_nxt : r_misr;
  assign w_bit_last = (r_bit == BIT_LAST);
  assign w_pat_inc  = r_pat + 1'b1;

  // Sequencer: outputs are registered for the state being entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_lfsr  <= LFSR_SEED;
      r_misr  <= '0;
      r_bit   <= '0;
      r_pat   <= '0;
      r_si    <= 1'b0;
      r_en    <= 1'b0;
      r_tm    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_sig   <= '0;
    end else begin
      r_misr <= w_misr_upd;
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state <= S_SETUP;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_busy  <= 1'b1;
            r_tm    <= 1'b1;
            r_lfsr  <= LFSR_SEED;
            r_misr  <= '0;
            r_pat   <= '0;
            r_en    <= 1'b0;
            r_si    <= 1'b0;
          end
        end
        S_SETUP: begin
          r_state <= S_SHIFT;
          r_bit   <= '0;
          r_en    <= 1'b1;
          r_si    <= r_lfsr[0];
          r_lfsr  <= w_lfsr_nxt;
        end
        S_SHIFT: begin
          if (w_bit_last) begin
            r_state <= S_CAPTURE;
            r_en    <= 1'b0;
            r_si    <= 1'b0;
          end else begin
            r_bit  <= r_bit + 1'b1;
            r_si   <= r_lfsr[0];
            r_lfsr <= w_lfsr_nxt;
          end
        end
        S_CAPTURE: begin
          r_pat <= w_pat_inc;
          r_bit <= '0;
          r_en  <= 1'b1;
          if (w_pat_inc == PAT_NUM) begin
            r_state <= S_UNLOAD;
            r_si    <= 1'b0;
          end else begin
            r_state <= S_SHIFT;
            r_si    <= r_lfsr[0];
            r_lfsr  <= w_lfsr_nxt;
          end
        end
        S_UNLOAD: begin
          if (w_bit_last) begin
            r_state <= S_DONE;
            r_en    <= 1'b0;
            r_busy  <= 1'b0;
            r_tm    <= 1'b0;
            r_done  <= 1'b1;
            r_sig   <= w_misr_upd;
            r_pass  <= (w_misr_upd == expected_sig);
          end else begin
            r_bit <= r_bit + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign scan_si   = r_si;
  assign scan_en   = r_en;
  assign test_mode = r_tm;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign signature = r_sig;

endmodule

// File: tb/tb_scan_bist_ctrl.sv
// tb_scan_bist_ctrl: directed runs against a timeline model of
// the scan sequence plus literal signature expectations.
module tb_scan_bist_ctrl;

  localparam int CL   = 4;
  localparam int NP   = 2;
  localparam int RUN  = 1 + NP * (CL + 1) + CL;
  localparam int BCL  = 64;
  localparam int BNP  = 16;
  localparam int BRUN = 1 + BNP * (BCL + 1) + BCL;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        start64 = 1'b0;
  logic [15:0] expected_sig = 16'h0000;

  logic        scan_so, scan_si, scan_en, test_mode;
  logic        busy, done, pass;
  logic [15:0] signature;

  logic        so64, si64, en64, tm64;
  logic        busy64, done64, pass64;
  logic [15:0] sig64;

  int n_vec = 0;
  int n_err = 0;

  int so_mode = 0;
  logic [CL-1:0]  chain   = '0;
  logic [BCL-1:0] chain64 = '0;

  scan_bist_ctrl #(
    .CHAIN_LEN(CL), .NUM_PATTERNS(NP), .LFSR_SEED(16'hACE1)
  ) u_dut (
    .clk(clk), .reset(reset), .start(start),
    .expected_sig(expected_sig), .scan_so(scan_so),
    .scan_si(scan_si), .scan_en(scan_en),
    .test_mode(test_mode), .busy(busy), .done(done),
    .pass(pass), .signature(signature)
  );

  scan_bist_ctrl u_dut64 (
    .clk(clk), .reset(reset), .start(start64),
    .expected_sig(expected_sig), .scan_so(so64),
    .scan_si(si64), .scan_en(en64),
    .test_mode(tm64), .busy(busy64), .done(done64),
    .pass(pass64), .signature(sig64)
  );

  // Scan chains: shift when enabled, hold on capture.
  always @(posedge clk) if (scan_en) chain <= {chain[CL-2:0], scan_si};
  always @(posedge clk) if (en64) chain64 <= {chain64[BCL-2:0], si64};

  assign scan_so = (so_mode == 0) ? 1'b0 :
                   (so_mode == 1) ? 1'b1 : chain[CL-1];
  assign so64 = chain64[BCL-1];

  // Pattern bit stream of the PRPG from the seed.
  bit lb [0:BNP*BCL-1];

  task automatic gen_bits();
    logic [15:0] l;
    l = 16'hACE1;
    for (int i = 0; i < BNP * BCL; i++) begin
      lb[i] = l[0];
      l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    end
  endtask

  // Signature of n compacted bits: 0 stream, 1 stream or PRPG loop.
  function automatic logic [15:0] misr_run(int mode, int n);
    logic [15:0] m;
    logic b;
    m = 16'h0000;
    for (int i = 0; i < n; i++) begin
      b = (mode == 1) ? 1'b1 : (mode == 2) ? lb[i] : 1'b0;
      m = {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10] ^ b};
    end
    return m;
  endfunction

  task automatic chk(string nm, int act, int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Model: cycle index since an accepted start; -1 = idle.
  int          m_t = -1;
  logic [15:0] m_sig = 16'h0000;
  logic [15:0] ref_sig = 16'h0000;
  logic        m_pass = 1'b0;
  bit          chk_en = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_t    <= -1;
      m_sig  <= 16'h0000;
      m_pass <= 1'b0;
    end else if (start && !(m_t >= 0 && m_t < RUN)) begin
      m_t    <= 0;
      m_pass <= 1'b0;
    end else if (m_t >= 0 && m_t < RUN) begin
      m_t <= m_t + 1;
      if (m_t == RUN - 1) begin
        m_sig  <= ref_sig;
        m_pass <= (ref_sig == expected_sig);
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  initial forever begin
    logic e_en, e_si, e_busy;
    int u, p, j;
    @(posedge clk);
    #2;
    if (chk_en) begin
      e_en = 1'b0;
      e_si = 1'b0;
      e_busy = (m_t >= 0 && m_t < RUN);
      if (m_t >= 1 && m_t < RUN) begin
        u = m_t - 1;
        if (u < NP * (CL + 1)) begin
          p = u / (CL + 1);
          j = u % (CL + 1);
          if (j < CL) begin
            e_en = 1'b1;
            e_si = lb[p * CL + j];
          end
        end else begin
          e_en = 1'b1;
        end
      end
      chk("busy", busy, e_busy);
      chk("test_mode", test_mode, e_busy);
      chk("done", done, m_t == RUN);
      chk("scan_en", scan_en, e_en);
      chk("scan_si", scan_si, e_si);
      chk("pass", pass, m_pass);
      if (!e_busy) chk("signature", signature, m_sig);
    end
  end

  task automatic set_mode(int md, logic [15:0] ex);
    @(negedge clk);
    so_mode = md;
    expected_sig = ex;
    ref_sig = misr_run(md, NP * CL);
  endtask

  task automatic run(input int pulse_at, output int len,
                     output logic [14:0] en_tr,
                     output logic [7:0] si_tr);
    int k;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    len = 0;
    k = 0;
    en_tr = '0;
    si_tr = '0;
    while (busy === 1'b1 && len < 3000) begin
      start = (len == pulse_at);
      en_tr = {en_tr[13:0], scan_en};
      if (scan_en && k < 8) begin
        si_tr[k] = scan_si;
        k++;
      end
      len++;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int len;
    logic [14:0] en_tr;
    logic [7:0] si_tr, v;
    gen_bits();
    repeat (3) @(negedge clk);
    for (int i = 0; i < 8; i++) v[i] = lb[i];
    chk("pin_lfsr8", v, 8'h4F);
    chk("pin_misr_ones8", misr_run(1, 8), 16'h00FF);
    chk("pin_misr_loop8", misr_run(2, 8), 16'h00F2);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sig", signature, 0);
    chk("rst_tm", test_mode, 0);
    reset = 1'b0;
    chk_en = 1'b1;

    set_mode(0, 16'h0000);
    run(-1, len, en_tr, si_tr);
    chk("len_zero", len, 15);
    chk("en_pattern", en_tr, 15'b011110111101111);
    chk("sig_zero", signature, 16'h0000);
    chk("pass_exp0", pass, 1);
    chk("done_zero", done, 1);

    set_mode(0, 16'h0001);
    run(-1, len, en_tr, si_tr);
    chk("pass_exp1", pass, 0);

    set_mode(2, 16'h00F2);
    run(-1, len, en_tr, si_tr);
    chk("si_seq", si_tr, 8'h4F);
    chk("sig_loop", signature, 16'h00F2);
    chk("pass_loop", pass, 1);

    set_mode(1, 16'h0000);
    run(-1, len, en_tr, si_tr);
    chk("sig_ones_1", signature, 16'h00FF);
    run(-1, len, en_tr, si_tr);
    chk("sig_ones_2", signature, 16'h00FF);
    chk("pass_ones", pass, 0);

    set_mode(2, 16'h00F2);
    run(3, len, en_tr, si_tr);
    chk("len_start_busy", len, RUN);
    chk("sig_start_busy", signature, 16'h00F2);

    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (7) @(negedge clk);
    chk("mid_busy", busy, 1);
    reset = 1'b1;
    start = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_en", scan_en, 0);
    chk("arst_tm", test_mode, 0);
    chk("arst_done", done, 0);
    chk("arst_pass", pass, 0);
    chk("arst_sig", signature, 0);
    repeat (2) @(negedge clk);
    start = 1'b0;
    @(negedge clk) reset = 1'b0;
    @(negedge clk);
    chk("rst_wins", busy, 0);
    run(-1, len, en_tr, si_tr);
    chk("len_after_rst", len, RUN);
    chk("sig_after_rst", signature, 16'h00F2);

    @(negedge clk);
    expected_sig = misr_run(2, BNP * BCL);
    @(negedge clk) start64 = 1'b1;
    @(negedge clk) start64 = 1'b0;
    len = 0;
    while (busy64 === 1'b1 && len < 3000) begin
      chk("tm64_busy", tm64, 1);
      len++;
      @(negedge clk);
    end
    chk("len64", len, BRUN);
    chk("tm64_done", tm64, 0);
    chk("done64", done64, 1);
    chk("sig64", sig64, misr_run(2, BNP * BCL));
    chk("pass64", pass64, 1);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
